// File: rtl/lke_cam_if.sv
// lke_cam_if: key/PHV handshake, result bus and entry config bundle of the CAM match stage.
// master: upstream/downstream/control side; slave: lke_cam_part.
// Optional LKE_CAM_HIT_CNT_EN adds hit_cnt/miss_cnt (slave outputs).
interface lke_cam_if #(
    parameter int PHV_LEN = 4*8*64+256,
    parameter int KEY_LEN = 197,
    parameter int IDX_W = 4
);
    logic [PHV_LEN-1:0] phv_in;
    logic [KEY_LEN-1:0] key_in;
    logic key_valid;
    logic ready_out;
    logic [PHV_LEN-1:0] phv_out;
    logic phv_valid_out;
    logic [7:0] match_addr;
    logic if_match;
    logic ready_in;
    logic cfg_wr_en;
    logic [IDX_W-1:0] cfg_index;
    logic [KEY_LEN-1:0] cfg_key;
    logic [KEY_LEN-1:0] cfg_mask;
    logic cfg_entry_valid;
    logic cfg_clear;
`ifdef LKE_CAM_HIT_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif
    modport master (
        output phv_in, key_in, key_valid, ready_in,
        output cfg_wr_en, cfg_index, cfg_key, cfg_mask, cfg_entry_valid, cfg_clear,
        input ready_out, phv_out, phv_valid_out, match_addr, if_match
`ifdef LKE_CAM_HIT_CNT_EN
        , input hit_cnt, miss_cnt
`endif
    );
    modport slave (
        input phv_in, key_in, key_valid, ready_in,
        input cfg_wr_en, cfg_index, cfg_key, cfg_mask, cfg_entry_valid, cfg_clear,
        output ready_out, phv_out, phv_valid_out, match_addr, if_match
`ifdef LKE_CAM_HIT_CNT_EN
        , output hit_cnt, miss_cnt
`endif
    );
endinterface

// File: rtl/lke_cam_part.sv
// lke_cam_part: two-stage ternary CAM match in front of the lookup RAM part.
// Ports: clk, rst (sync, active high), bus (lke_cam_if.slave): key/PHV in with
// key_valid/ready_out, PHV + match_addr/if_match out with phv_valid_out/ready_in,
// and the cfg_* entry write/clear port.
// Macro LKE_CAM_HIT_CNT_EN adds hit_cnt/miss_cnt transfer counters.
module lke_cam_part #(
    parameter int PHV_LEN = 4*8*64+256,
    parameter int KEY_LEN = 197,
    parameter int NUM_ENTRIES = 16,
    parameter int IDX_W = 4
) (
    input logic clk,
    input logic rst,
    lke_cam_if.slave bus
);
    logic [KEY_LEN-1:0] ent_key [NUM_ENTRIES];
    logic [KEY_LEN-1:0] ent_mask [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [NUM_ENTRIES-1:0] hit;
    logic [NUM_ENTRIES-1:0] s1_hit;
    logic [PHV_LEN-1:0] s1_phv;
    logic s1_valid;
    logic advance;
    logic [7:0] enc;

    assign advance = !bus.phv_valid_out || bus.ready_in;
    assign bus.ready_out = advance;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            hit[i] = ent_valid[i] && ((bus.key_in ^ ent_key[i]) & ent_mask[i]) == '0;
    end

    // Scan downward so the lowest hitting index is the last one written.
    always_comb begin
        enc = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--)
            if (s1_hit[i]) enc = 8'(i);
    end

    // Indices at or above NUM_ENTRIES never match a loop index, so such writes drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_key[i] <= '0;
                ent_mask[i] <= '0;
            end
        end else if (bus.cfg_clear) begin
            ent_valid <= '0;
        end else if (bus.cfg_wr_en) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                if (bus.cfg_index == IDX_W'(i)) begin
                    ent_key[i] <= bus.cfg_key;
                    ent_mask[i] <= bus.cfg_mask;
                    ent_valid[i] <= bus.cfg_entry_valid;
                end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_phv <= '0;
            s1_valid <= 1'b0;
            s1_hit <= '0;
            bus.phv_out <= '0;
            bus.phv_valid_out <= 1'b0;
            bus.match_addr <= '0;
            bus.if_match <= 1'b0;
        end else if (advance) begin
            s1_phv <= bus.phv_in;
            s1_valid <= bus.key_valid;
            s1_hit <= hit;
            bus.phv_out <= s1_phv;
            bus.phv_valid_out <= s1_valid;
            bus.match_addr <= enc;
            bus.if_match <= |s1_hit;
        end
    end

`ifdef LKE_CAM_HIT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || bus.cfg_clear) begin
            bus.hit_cnt <= '0;
            bus.miss_cnt <= '0;
        end else if (bus.phv_valid_out && bus.ready_in) begin
            bus.hit_cnt <= bus.hit_cnt + {31'd0, bus.if_match};
            bus.miss_cnt <= bus.miss_cnt + {31'd0, !bus.if_match};
        end
    end
`endif
endmodule

// File: tb/tb_lke_cam_part.sv
// tb_lke_cam_part: scoreboard bench for lke_cam_part with a table-level reference model.
module tb_lke_cam_part;
    localparam int PHV_LEN = 4*8*64+256;
    localparam int KEY_LEN = 197;
    localparam int NE = 12;
    localparam int IDX_W = 4;
    typedef logic [KEY_LEN-1:0] key_t;
    typedef logic [PHV_LEN-1:0] phv_t;
    typedef struct {
        phv_t phv;
        logic hit;
        logic [7:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lke_cam_if #(.PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .IDX_W(IDX_W)) bus ();
    lke_cam_part #(.PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .NUM_ENTRIES(NE), .IDX_W(IDX_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int passed = 0;
    int total = 0;
    key_t mk [NE];
    key_t mm [NE];
    bit mv [NE];
    bit acc = 0;
    key_t pool [6];

    task automatic chk(string n, logic [63:0] got, logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", n, got, want, $time);
    endtask

    function automatic key_t rkey();
        key_t k = '0;
        repeat (7) k = (k << 32) | key_t'($urandom);
        return k;
    endfunction

    function automatic phv_t rphv();
        phv_t p = '0;
        repeat (72) p = (p << 32) | phv_t'($urandom);
        return p;
    endfunction

    // First table entry (in index order) whose cared-about bits equal the key's.
    function automatic exp_t lookup(key_t k, phv_t p);
        exp_t e;
        e.phv = p;
        e.hit = 1'b0;
        e.addr = 8'd0;
        for (int i = 0; i < NE; i++)
            if (mv[i] && (k & mm[i]) == (mk[i] & mm[i])) begin
                e.hit = 1'b1;
                e.addr = 8'(i);
                return e;
            end
        return e;
    endfunction

    // Called at posedge+1 with inputs set; resolves the upcoming edge in the model.
    task automatic step();
        #1;
        acc = 0;
        if (rst) begin
            q.delete();
            for (int i = 0; i < NE; i++) begin
                mk[i] = '0;
                mm[i] = '0;
                mv[i] = 0;
            end
        end else begin
            if (bus.key_valid && bus.ready_out) begin
                acc = 1;
                q.push_back(lookup(bus.key_in, bus.phv_in));
            end
            if (bus.cfg_clear) begin
                for (int i = 0; i < NE; i++) mv[i] = 0;
            end else if (bus.cfg_wr_en && int'(bus.cfg_index) < NE) begin
                mk[bus.cfg_index] = bus.cfg_key;
                mm[bus.cfg_index] = bus.cfg_mask;
                mv[bus.cfg_index] = bus.cfg_entry_valid;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(key_t k, phv_t p);
        bus.key_in = k;
        bus.phv_in = p;
        bus.key_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", bus.ready_out, 1);
        bus.key_valid = 1'b0;
    endtask

    task automatic wr(int idx, key_t k, key_t m, logic v);
        bus.cfg_index = IDX_W'(idx);
        bus.cfg_key = k;
        bus.cfg_mask = m;
        bus.cfg_entry_valid = v;
        bus.cfg_wr_en = 1'b1;
        step();
        bus.cfg_wr_en = 1'b0;
    endtask

    task automatic drain();
        bus.key_valid = 1'b0;
        bus.ready_in = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) step();
        step();
        chk("drain_pending", 64'(q.size()), 0);
    endtask

    task automatic clear();
        bus.cfg_clear = 1'b1;
        step();
        bus.cfg_clear = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every downstream transfer, checks stall stability.
    phv_t lphv;
    logic lhit;
    logic [7:0] laddr;
    bit pstall = 0;
`ifdef LKE_CAM_HIT_CNT_EN
    int unsigned mhit = 0;
    int unsigned mmiss = 0;
`endif
    always @(negedge clk) begin
        exp_t e;
        bit xfer;
        e.hit = 1'b0;
        xfer = !rst && bus.phv_valid_out && bus.ready_in;
`ifdef LKE_CAM_HIT_CNT_EN
        chk("hit_cnt", 64'(bus.hit_cnt), 64'(mhit));
        chk("miss_cnt", 64'(bus.miss_cnt), 64'(mmiss));
`endif
        if (!rst) begin
            chk("ready_out", bus.ready_out, !bus.phv_valid_out || bus.ready_in);
            if (pstall) begin
                chk("stall_valid", bus.phv_valid_out, 1);
                chk("stall_phv", bus.phv_out == lphv, 1);
                chk("stall_if_match", bus.if_match, lhit);
                chk("stall_addr", bus.match_addr, laddr);
            end
            if (xfer) begin
                if (q.size() == 0) chk("spurious_out", bus.phv_valid_out, 0);
                else begin
                    e = q.pop_front();
                    chk("phv_out", bus.phv_out == e.phv, 1);
                    chk("if_match", bus.if_match, e.hit);
                    chk("match_addr", bus.match_addr, e.addr);
                end
            end
            pstall = bus.phv_valid_out && !bus.ready_in;
            lphv = bus.phv_out;
            lhit = bus.if_match;
            laddr = bus.match_addr;
        end else pstall = 0;
`ifdef LKE_CAM_HIT_CNT_EN
        if (rst || bus.cfg_clear) begin
            mhit = 0;
            mmiss = 0;
        end else if (xfer) begin
            if (e.hit) mhit++;
            else mmiss++;
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    initial begin
        key_t k;
        key_t ka;
        phv_t p;
        bus.phv_in = '0;
        bus.key_in = '0;
        bus.key_valid = 1'b0;
        bus.ready_in = 1'b0;
        bus.cfg_wr_en = 1'b0;
        bus.cfg_index = '0;
        bus.cfg_key = '0;
        bus.cfg_mask = '0;
        bus.cfg_entry_valid = 1'b0;
        bus.cfg_clear = 1'b0;
        for (int i = 0; i < 6; i++) pool[i] = rkey();
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid", bus.phv_valid_out, 0);
        chk("rst_if_match", bus.if_match, 0);
        chk("rst_addr", bus.match_addr, 0);
        chk("rst_phv", bus.phv_out == '0, 1);
        chk("rst_ready_out", bus.ready_out, 1);

        // Exact entry 3, with explicit two-cycle latency.
        wr(3, key_t'(16'h1234), '1, 1'b1);
        bus.ready_in = 1'b1;
        p = rphv();
        send(key_t'(16'h1234), p);
        chk("lat1_valid", bus.phv_valid_out, 0);
        step();
        chk("lat2_valid", bus.phv_valid_out, 1);
        chk("lat2_if_match", bus.if_match, 1);
        chk("lat2_addr", bus.match_addr, 3);
        chk("lat2_phv", bus.phv_out == p, 1);
        drain();

        // Priority: exact entry 2 beats wildcard entry 5, then 5 alone.
        wr(5, key_t'(8'hAB), '0, 1'b1);
        wr(2, key_t'(8'hAB), '1, 1'b1);
        send(key_t'(8'hAB), rphv());
        wr(2, key_t'(8'hAB), '1, 1'b0);
        send(key_t'(8'hAB), rphv());
        drain();

        // Empty table miss.
        clear();
        send(key_t'(8'h55), rphv());
        drain();

        // A, B, C with a three-cycle stall while A is presented.
        send(pool[0], rphv());
        send(pool[1], rphv());
        bus.key_in = pool[2];
        bus.phv_in = rphv();
        bus.key_valid = 1'b1;
        bus.ready_in = 1'b0;
        repeat (3) begin
            step();
            chk("stall_accept", acc, 0);
            chk("stall_ready_out", bus.ready_out, 0);
        end
        bus.ready_in = 1'b1;
        for (int n = 0; n < 5 && !acc; n++) step();
        chk("stall_c_accept", acc, 1);
        drain();

        // Write and lookup in the same cycle, then clear beating a write.
        k = pool[3];
        bus.cfg_index = IDX_W'(1);
        bus.cfg_key = k;
        bus.cfg_mask = '1;
        bus.cfg_entry_valid = 1'b1;
        bus.cfg_wr_en = 1'b1;
        bus.key_in = k;
        bus.phv_in = rphv();
        bus.key_valid = 1'b1;
        step();
        chk("same_cycle_accept", acc, 1);
        bus.cfg_wr_en = 1'b0;
        bus.key_valid = 1'b0;
        send(k, rphv());
        bus.cfg_index = IDX_W'(4);
        bus.cfg_wr_en = 1'b1;
        bus.cfg_clear = 1'b1;
        step();
        bus.cfg_wr_en = 1'b0;
        bus.cfg_clear = 1'b0;
        send(k, rphv());
        drain();

        // Out-of-range index is dropped.
        wr(13, pool[4], '0, 1'b1);
        send(pool[5], rphv());
        drain();

        // Reset with lookups in flight discards them.
        wr(0, pool[0], '0, 1'b1);
        bus.ready_in = 1'b0;
        send(pool[0], rphv());
        send(pool[1], rphv());
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", bus.phv_valid_out, 0);
        chk("midrst_ready_out", bus.ready_out, 1);
        bus.ready_in = 1'b1;
        repeat (5) step();

`ifdef LKE_CAM_HIT_CNT_EN
        clear();
        ka = pool[2];
        wr(0, ka, '1, 1'b1);
        repeat (4) send(ka, rphv());
        repeat (2) send(~ka, rphv());
        drain();
        chk("cnt_hit4", 64'(bus.hit_cnt), 4);
        chk("cnt_miss2", 64'(bus.miss_cnt), 2);
        clear();
        chk("cnt_hit_clr", 64'(bus.hit_cnt), 0);
        chk("cnt_miss_clr", 64'(bus.miss_cnt), 0);
`else
        ka = '0;
`endif

        // Randomized traffic, config churn and backpressure.
        acc = 0;
        bus.key_valid = 1'b0;
        for (int c = 0; c < 800; c++) begin
            int r;
            bus.ready_in = $urandom_range(0, 9) < 7;
            if (!bus.key_valid || acc) begin
                k = pool[$urandom_range(0, 5)];
                if ($urandom_range(0, 2) == 0) k[$urandom_range(0, KEY_LEN - 1)] ^= 1'b1;
                if ($urandom_range(0, 9) == 0) k = rkey() ^ ka;
                bus.key_in = k;
                bus.phv_in = rphv();
                bus.key_valid = $urandom_range(0, 3) != 0;
            end
            bus.cfg_wr_en = $urandom_range(0, 5) == 0;
            bus.cfg_index = IDX_W'($urandom_range(0, 15));
            bus.cfg_key = pool[$urandom_range(0, 5)];
            r = $urandom_range(0, 9);
            bus.cfg_mask = r < 5 ? '1 : r == 5 ? '0 : rkey();
            bus.cfg_entry_valid = $urandom_range(0, 3) != 0;
            bus.cfg_clear = $urandom_range(0, 59) == 0;
            step();
        end
        bus.cfg_wr_en = 1'b0;
        bus.cfg_clear = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
